// File: rtl/jtag_uart_stream_bridge_if.sv
// Stream and Avalon-MM signal bundle between the byte-stream bridge and its neighbours.
// master = bridge side; slave = stream producer/consumer plus UART register slave.
interface jtag_uart_stream_bridge_if;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        avm_chipselect;
    logic        avm_address;
    logic        avm_read_n;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        input  tx_data, tx_valid, rx_ready, avm_readdata, avm_waitrequest,
        output tx_ready, rx_data, rx_valid,
               avm_chipselect, avm_address, avm_read_n, avm_write_n, avm_writedata
    );

    modport slave (
        output tx_data, tx_valid, rx_ready, avm_readdata, avm_waitrequest,
        input  tx_ready, rx_data, rx_valid,
               avm_chipselect, avm_address, avm_read_n, avm_write_n, avm_writedata
    );
endinterface

// File: rtl/jtag_uart_stream_bridge.sv
// Avalon-MM master turning the JTAG UART data/control registers into TX/RX byte streams; one ARB cycle precedes every transfer.
// TX stalls (tx_ready low) until polled write-FIFO credit exists; RX data reads pause while rx_valid waits for rx_ready.
module jtag_uart_stream_bridge #(
    parameter int POLL_INTERVAL = 64,
    parameter int CNT_W         = 16
) (
    input  logic                      clk_1_clk,
    input  logic                      reset_1_reset_n,
    jtag_uart_stream_bridge_if.master bus,
    output logic [15:0]               tx_credit
);
    typedef enum logic [1:0] {ARB, WR_DATA, RD_CTRL, RD_DATA} state_t;

    localparam logic [CNT_W-1:0] POLL_RELOAD  = CNT_W'(POLL_INTERVAL - 1);
    localparam logic [CNT_W-1:0] BACKOFF_LOAD = CNT_W'(POLL_INTERVAL);

    state_t           r_state;
    logic [CNT_W-1:0] r_poll_cnt;
    logic [CNT_W-1:0] r_backoff;
    logic             r_rx_due;
    logic [15:0]      r_tx_credit;
    logic             r_cs;
    logic             r_addr;
    logic             r_rd_n;
    logic             r_wr_n;
    logic [31:0]      r_wdata;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;

    logic w_in_arb;
    logic w_pick_rd;
    logic w_pick_wr;
    logic w_pick_ctrl;
    logic w_done;
    logic w_poll_hit;
    logic w_rvalid;
    logic w_ravail_nz;

    assign w_in_arb    = (r_state == ARB);
    assign w_pick_rd   = w_in_arb && r_rx_due && !r_rx_valid;
    assign w_pick_wr   = w_in_arb && !w_pick_rd && bus.tx_valid && (r_tx_credit != 16'd0);
    assign w_pick_ctrl = w_in_arb && !w_pick_rd && bus.tx_valid && (r_tx_credit == 16'd0)
                         && (r_backoff == '0);
    assign w_done      = !w_in_arb && !bus.avm_waitrequest;
    assign w_poll_hit  = (r_poll_cnt == '0);
    assign w_rvalid    = bus.avm_readdata[15];
    assign w_ravail_nz = (bus.avm_readdata[31:16] != 16'd0);

    // The accept strobe has to coincide with the ARB cycle that latches the byte.
    assign bus.tx_ready       = w_pick_wr;
    assign bus.rx_data        = r_rx_data;
    assign bus.rx_valid       = r_rx_valid;
    assign bus.avm_chipselect = r_cs;
    assign bus.avm_address    = r_addr;
    assign bus.avm_read_n     = r_rd_n;
    assign bus.avm_write_n    = r_wr_n;
    assign bus.avm_writedata  = r_wdata;
    assign tx_credit          = r_tx_credit;

    always_ff @(posedge clk_1_clk or negedge reset_1_reset_n) begin
        if (!reset_1_reset_n) begin
            r_state     <= ARB;
            r_poll_cnt  <= POLL_RELOAD;
            r_backoff   <= '0;
            r_rx_due    <= 1'b0;
            r_tx_credit <= 16'd0;
            r_cs        <= 1'b0;
            r_addr      <= 1'b0;
            r_rd_n      <= 1'b1;
            r_wr_n      <= 1'b1;
            r_wdata     <= 32'd0;
            r_rx_data   <= 8'd0;
            r_rx_valid  <= 1'b0;
        end else begin
            r_poll_cnt <= w_poll_hit ? POLL_RELOAD : r_poll_cnt - 1'b1;
            if (r_backoff != '0) begin
                r_backoff <= r_backoff - 1'b1;
            end
            if (r_rx_valid && bus.rx_ready) begin
                r_rx_valid <= 1'b0;
            end
            // A fresh poll tick outranks the clear from a finishing data read.
            if (w_poll_hit) begin
                r_rx_due <= 1'b1;
            end else if ((r_state == RD_DATA) && w_done && !(w_rvalid && w_ravail_nz)) begin
                r_rx_due <= 1'b0;
            end

            case (r_state)
                ARB: begin
                    if (w_pick_rd) begin
                        r_state <= RD_DATA;
                        r_cs    <= 1'b1;
                        r_addr  <= 1'b0;
                        r_rd_n  <= 1'b0;
                    end else if (w_pick_wr) begin
                        r_state <= WR_DATA;
                        r_cs    <= 1'b1;
                        r_addr  <= 1'b0;
                        r_wr_n  <= 1'b0;
                        r_wdata <= {24'd0, bus.tx_data};
                    end else if (w_pick_ctrl) begin
                        r_state <= RD_CTRL;
                        r_cs    <= 1'b1;
                        r_addr  <= 1'b1;
                        r_rd_n  <= 1'b0;
                    end
                end
                WR_DATA: begin
                    if (w_done) begin
                        r_state     <= ARB;
                        r_cs        <= 1'b0;
                        r_wr_n      <= 1'b1;
                        r_tx_credit <= r_tx_credit - 16'd1;
                    end
                end
                RD_CTRL: begin
                    if (w_done) begin
                        r_state     <= ARB;
                        r_cs        <= 1'b0;
                        r_rd_n      <= 1'b1;
                        r_tx_credit <= bus.avm_readdata[31:16];
                        if (!w_ravail_nz) begin
                            r_backoff <= BACKOFF_LOAD;
                        end
                    end
                end
                RD_DATA: begin
                    if (w_done) begin
                        r_state <= ARB;
                        r_cs    <= 1'b0;
                        r_rd_n  <= 1'b1;
                        if (w_rvalid) begin
                            r_rx_data  <= bus.avm_readdata[7:0];
                            r_rx_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ARB;
                    r_cs    <= 1'b0;
                    r_rd_n  <= 1'b1;
                    r_wr_n  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_jtag_uart_stream_bridge.sv
// Directed bench: behavioural UART slave with programmable stall, bus monitor, and per-feature test tasks.
module tb_jtag_uart_stream_bridge;
    localparam int P = 16;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] tx_credit;

    logic        drv_tx_valid = 1'b0;
    logic [7:0]  drv_tx_data  = 8'd0;
    logic        drv_rx_ready = 1'b0;
    logic        drv_wait     = 1'b0;
    logic [31:0] drv_rdata    = 32'hFFFF_FFFF;

    jtag_uart_stream_bridge_if bus();
    assign bus.tx_valid        = drv_tx_valid;
    assign bus.tx_data         = drv_tx_data;
    assign bus.rx_ready        = drv_rx_ready;
    assign bus.avm_waitrequest = drv_wait;
    assign bus.avm_readdata    = drv_rdata;

    jtag_uart_stream_bridge #(.POLL_INTERVAL(P), .CNT_W(16)) dut (
        .clk_1_clk       (clk),
        .reset_1_reset_n (rst_n),
        .bus             (bus),
        .tx_credit       (tx_credit)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Stimulus-side state (written only by the main initial block)
    int          stall_cfg = 0;
    logic [31:0] ctrl_rd   = 32'd0;
    logic [31:0] data_rd   = 32'd0;
    logic [7:0]  tx_buf [0:255];
    int          tx_wr     = 0;

    // Monitor-side state (written only by the negedge monitor)
    int          tx_acc = 0, rdy_err = 0;
    int          n_wr = 0, n_rdc = 0, n_rdd = 0, rdc_start = 0, rdd_start = 0;
    int          stab_err = 0, strobe_err = 0, gap_err = 0, viol = 0;
    int          first_type = 0, wr_len = 0;
    logic [31:0] wlog [0:255];
    logic        walog [0:255];
    int          rdc_at_wr [0:255];
    bit          in_xfer = 0, just_done = 0;
    int          stall_left = 0, xlen = 0, cur_type = 0;
    logic        s_addr, s_rd, s_wr;
    logic [31:0] s_wd;

    // TX source: present the next unaccepted byte just after each rising edge
    always @(posedge clk) begin
        #1;
        if (tx_acc < tx_wr) begin
            drv_tx_valid = 1'b1;
            drv_tx_data  = tx_buf[tx_acc % 256];
        end else begin
            drv_tx_valid = 1'b0;
            drv_tx_data  = 8'd0;
        end
    end

    // UART slave + bus monitor; type codes 1=write, 2=control read, 3=data read
    always @(negedge clk) begin
        if (!rst_n) begin
            in_xfer = 0; just_done = 0; first_type = 0;
            drv_wait = 1'b0; drv_rdata = 32'hFFFF_FFFF;
        end else begin
            if (bus.tx_valid && bus.tx_ready) tx_acc++;
            if (bus.tx_ready && !bus.tx_valid) rdy_err++;
            if (bus.avm_chipselect) begin
                if (just_done) gap_err++;
                if (!in_xfer) begin
                    in_xfer = 1; xlen = 0; stall_left = stall_cfg;
                    s_addr = bus.avm_address; s_wd = bus.avm_writedata;
                    s_rd = bus.avm_read_n; s_wr = bus.avm_write_n;
                    cur_type = !s_wr ? 1 : (s_addr ? 2 : 3);
                    if (first_type == 0) first_type = cur_type;
                    if (cur_type == 2) rdc_start++;
                    if (cur_type == 3) begin
                        rdd_start++;
                        if (bus.rx_valid) viol++;
                    end
                    if (s_rd !== (cur_type == 1)) strobe_err++;
                end else if (bus.avm_address !== s_addr || bus.avm_writedata !== s_wd ||
                             bus.avm_read_n !== s_rd || bus.avm_write_n !== s_wr) begin
                    stab_err++;
                end
                xlen++;
                just_done = 0;
                if (stall_left > 0) begin
                    stall_left--;
                    drv_wait = 1'b1; drv_rdata = 32'hFFFF_FFFF;
                end else begin
                    drv_wait = 1'b0;
                    drv_rdata = s_addr ? ctrl_rd : data_rd;
                    in_xfer = 0; just_done = 1;
                    case (cur_type)
                        1: begin
                            wlog[n_wr % 256] = s_wd; walog[n_wr % 256] = s_addr;
                            rdc_at_wr[n_wr % 256] = n_rdc; wr_len = xlen; n_wr++;
                        end
                        2: n_rdc++;
                        default: n_rdd++;
                    endcase
                end
            end else begin
                in_xfer = 0; just_done = 0;
                drv_wait = 1'b0; drv_rdata = 32'hFFFF_FFFF;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        tx_buf[tx_wr % 256] = b;
        tx_wr++;
    endtask

    function automatic int cnt_of(input int which);
        case (which)
            0:       return n_wr;
            1:       return n_rdc;
            2:       return n_rdd;
            3:       return rdd_start;
            default: return rdc_start;
        endcase
    endfunction

    task automatic wait_for(input int which, input int target, input int budget, output bit ok);
        int b = budget;
        while (cnt_of(which) < target && b > 0) begin
            tick();
            b--;
        end
        ok = (cnt_of(which) >= target);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        tests++; if (bus.avm_chipselect !== 1'b0) begin fails++; $display("FAIL rst_cs got %0b want 0", bus.avm_chipselect); end
        tests++; if (bus.avm_read_n !== 1'b1) begin fails++; $display("FAIL rst_read_n got %0b want 1", bus.avm_read_n); end
        tests++; if (bus.avm_write_n !== 1'b1) begin fails++; $display("FAIL rst_write_n got %0b want 1", bus.avm_write_n); end
        tests++; if (bus.avm_address !== 1'b0) begin fails++; $display("FAIL rst_address got %0b want 0", bus.avm_address); end
        tests++; if (bus.avm_writedata !== 32'd0) begin fails++; $display("FAIL rst_writedata got %h want 0", bus.avm_writedata); end
        tests++; if (bus.tx_ready !== 1'b0) begin fails++; $display("FAIL rst_tx_ready got %0b want 0", bus.tx_ready); end
        tests++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL rst_rx_valid got %0b want 0", bus.rx_valid); end
        tests++; if (bus.rx_data !== 8'd0) begin fails++; $display("FAIL rst_rx_data got %h want 0", bus.rx_data); end
        tests++; if (tx_credit !== 16'd0) begin fails++; $display("FAIL rst_tx_credit got %0d want 0", tx_credit); end
        rst_n = 1'b1;
    endtask

    task automatic test_tx_basic();
        int w0, c0, a0;
        bit ok;
        ctrl_rd = 32'h0040_0000;
        w0 = n_wr; c0 = n_rdc; a0 = tx_acc;
        push(8'h41);
        wait_for(1, c0 + 1, 30, ok);
        tests++; if (!ok) begin fails++; $display("FAIL tx_ctrl_read timeout got %0d want %0d", n_rdc, c0 + 1); end
        tests++; if (n_wr !== w0) begin fails++; $display("FAIL tx_write_before_ctrl got %0d want %0d", n_wr, w0); end
        tests++; if (first_type !== 2) begin fails++; $display("FAIL tx_first_action got %0d want 2", first_type); end
        tick();
        tests++; if (tx_credit !== 16'd64) begin fails++; $display("FAIL tx_credit_loaded got %0d want 64", tx_credit); end
        wait_for(0, w0 + 1, 30, ok);
        tests++; if (!ok) begin fails++; $display("FAIL tx_write timeout got %0d want %0d", n_wr, w0 + 1); end
        tests++; if (wlog[w0 % 256] !== 32'h0000_0041) begin fails++; $display("FAIL tx_writedata got %h want 00000041", wlog[w0 % 256]); end
        tests++; if (walog[w0 % 256] !== 1'b0) begin fails++; $display("FAIL tx_write_addr got %0b want 0", walog[w0 % 256]); end
        tick();
        tests++; if (tx_credit !== 16'd63) begin fails++; $display("FAIL tx_credit_dec got %0d want 63", tx_credit); end
        repeat (10) tick();
        tests++; if (tx_acc - a0 !== 1) begin fails++; $display("FAIL tx_ready_pulses got %0d want 1", tx_acc - a0); end
        tests++; if (n_wr !== w0 + 1) begin fails++; $display("FAIL tx_write_count got %0d want %0d", n_wr, w0 + 1); end
    endtask

    task automatic test_wait_stall();
        int w0;
        bit ok;
        stall_cfg = 5;
        w0 = n_wr;
        push(8'h5A);
        wait_for(0, w0 + 1, 200, ok);
        tests++; if (!ok) begin fails++; $display("FAIL stall_write timeout got %0d want %0d", n_wr, w0 + 1); end
        tests++; if (wr_len !== 6) begin fails++; $display("FAIL stall_write_cycles got %0d want 6", wr_len); end
        tests++; if (wlog[w0 % 256] !== 32'h0000_005A) begin fails++; $display("FAIL stall_writedata got %h want 0000005a", wlog[w0 % 256]); end
        repeat (20) tick();
        tests++; if (n_wr !== w0 + 1) begin fails++; $display("FAIL stall_write_count got %0d want %0d", n_wr, w0 + 1); end
        tests++; if (stab_err !== 0) begin fails++; $display("FAIL stall_stability got %0d want 0", stab_err); end
        tests++; if (tx_credit !== 16'd62) begin fails++; $display("FAIL stall_credit got %0d want 62", tx_credit); end
        stall_cfg = 0;
    endtask

    task automatic test_backoff();
        int w0, c0, cs0;
        bit ok;
        rst_n = 1'b0;
        repeat (2) tick();
        ctrl_rd = 32'h0000_0000;
        rst_n = 1'b1;
        w0 = n_wr; c0 = n_rdc;
        push(8'h61); push(8'h62); push(8'h63);
        wait_for(1, c0 + 1, 30, ok);
        tests++; if (!ok) begin fails++; $display("FAIL bo_first_ctrl timeout got %0d want %0d", n_rdc, c0 + 1); end
        cs0 = rdc_start;
        ctrl_rd = 32'h0002_0000;
        repeat (P) tick();
        tests++; if (rdc_start !== cs0) begin fails++; $display("FAIL bo_no_repoll got %0d want %0d", rdc_start, cs0); end
        tests++; if (n_wr !== w0) begin fails++; $display("FAIL bo_no_write got %0d want %0d", n_wr, w0); end
        wait_for(0, w0 + 2, 80, ok);
        tests++; if (!ok) begin fails++; $display("FAIL bo_two_writes timeout got %0d want %0d", n_wr, w0 + 2); end
        tick();
        tests++; if (tx_credit !== 16'd0) begin fails++; $display("FAIL bo_credit_exhausted got %0d want 0", tx_credit); end
        wait_for(0, w0 + 3, 80, ok);
        tests++; if (!ok) begin fails++; $display("FAIL bo_third_write timeout got %0d want %0d", n_wr, w0 + 3); end
        tests++; if (rdc_at_wr[(w0 + 1) % 256] !== rdc_at_wr[w0 % 256]) begin fails++; $display("FAIL bo_pair_one_poll got %0d want %0d", rdc_at_wr[(w0 + 1) % 256], rdc_at_wr[w0 % 256]); end
        tests++; if (rdc_at_wr[(w0 + 2) % 256] <= rdc_at_wr[(w0 + 1) % 256]) begin fails++; $display("FAIL bo_third_after_poll got %0d want >%0d", rdc_at_wr[(w0 + 2) % 256], rdc_at_wr[(w0 + 1) % 256]); end
        tests++; if (wlog[w0 % 256] !== 32'h61 || wlog[(w0 + 1) % 256] !== 32'h62 || wlog[(w0 + 2) % 256] !== 32'h63) begin
            fails++; $display("FAIL bo_write_order got %h %h %h want 61 62 63", wlog[w0 % 256], wlog[(w0 + 1) % 256], wlog[(w0 + 2) % 256]);
        end
        tick();
        tests++; if (tx_credit !== 16'd1) begin fails++; $display("FAIL bo_final_credit got %0d want 1", tx_credit); end
    endtask

    task automatic test_rx();
        int d0, s0;
        bit ok;
        drv_rx_ready = 1'b0;
        data_rd = 32'h0003_8055;
        d0 = n_rdd;
        wait_for(2, d0 + 1, 60, ok);
        tests++; if (!ok) begin fails++; $display("FAIL rx_read timeout got %0d want %0d", n_rdd, d0 + 1); end
        tick();
        tests++; if (bus.rx_valid !== 1'b1) begin fails++; $display("FAIL rx_valid_set got %0b want 1", bus.rx_valid); end
        tests++; if (bus.rx_data !== 8'h55) begin fails++; $display("FAIL rx_data_first got %h want 55", bus.rx_data); end
        s0 = rdd_start;
        repeat (3 * P) tick();
        tests++; if (rdd_start !== s0) begin fails++; $display("FAIL rx_hold_no_read got %0d want %0d", rdd_start, s0); end
        tests++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h55) begin fails++; $display("FAIL rx_hold_data got %0b/%h want 1/55", bus.rx_valid, bus.rx_data); end
        data_rd = 32'h0002_8066;
        drv_rx_ready = 1'b1;
        tick();
        drv_rx_ready = 1'b0;
        tests++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL rx_valid_clear got %0b want 0", bus.rx_valid); end
        wait_for(3, s0 + 1, 3, ok);
        tests++; if (!ok) begin fails++; $display("FAIL rx_prompt_drain got %0d want %0d", rdd_start, s0 + 1); end
        wait_for(2, d0 + 2, 20, ok);
        tick();
        tests++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h66) begin fails++; $display("FAIL rx_second_byte got %0b/%h want 1/66", bus.rx_valid, bus.rx_data); end
        data_rd = 32'h0000_0000;
        drv_rx_ready = 1'b1;
        tick();
        drv_rx_ready = 1'b0;
        repeat (10) tick();
        tests++; if (n_rdd !== d0 + 3) begin fails++; $display("FAIL rx_empty_read_count got %0d want %0d", n_rdd, d0 + 3); end
        tests++; if (bus.rx_valid !== 1'b0 || bus.rx_data !== 8'h66) begin fails++; $display("FAIL rx_empty_hold got %0b/%h want 0/66", bus.rx_valid, bus.rx_data); end
        tests++; if (viol !== 0) begin fails++; $display("FAIL rx_read_while_valid got %0d want 0", viol); end
    endtask

    task automatic test_reset_mid();
        int s0, w0;
        bit ok;
        stall_cfg = 1000;
        s0 = rdd_start;
        wait_for(3, s0 + 1, 40, ok);
        tests++; if (!ok) begin fails++; $display("FAIL rm_stall_start timeout got %0d want %0d", rdd_start, s0 + 1); end
        repeat (2) tick();
        tests++; if (bus.avm_chipselect !== 1'b1 || bus.avm_read_n !== 1'b0) begin fails++; $display("FAIL rm_stalled_read got cs=%0b rd_n=%0b want 1/0", bus.avm_chipselect, bus.avm_read_n); end
        rst_n = 1'b0;
        #1;
        tests++; if (bus.avm_chipselect !== 1'b0 || bus.avm_read_n !== 1'b1 || bus.avm_write_n !== 1'b1) begin
            fails++; $display("FAIL rm_async_idle got cs=%0b rd_n=%0b wr_n=%0b want 0/1/1", bus.avm_chipselect, bus.avm_read_n, bus.avm_write_n);
        end
        tests++; if (tx_credit !== 16'd0) begin fails++; $display("FAIL rm_credit got %0d want 0", tx_credit); end
        tests++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL rm_rx_valid got %0b want 0", bus.rx_valid); end
        stall_cfg = 0;
        ctrl_rd = 32'h0040_0000;
        w0 = n_wr;
        push(8'h77);
        repeat (3) tick();
        rst_n = 1'b1;
        wait_for(0, w0 + 1, 60, ok);
        tests++; if (!ok) begin fails++; $display("FAIL rm_write timeout got %0d want %0d", n_wr, w0 + 1); end
        tests++; if (first_type !== 2 && first_type !== 3) begin fails++; $display("FAIL rm_first_action got %0d want 2 or 3", first_type); end
        tests++; if (wlog[w0 % 256] !== 32'h0000_0077) begin fails++; $display("FAIL rm_writedata got %h want 00000077", wlog[w0 % 256]); end
        tests++; if (gap_err !== 0 || strobe_err !== 0 || rdy_err !== 0) begin
            fails++; $display("FAIL rm_bus_protocol got gap=%0d strobe=%0d rdy=%0d want 0/0/0", gap_err, strobe_err, rdy_err);
        end
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_wait_stall();
        test_backoff();
        test_rx();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired after %0t", $time);
        $fatal(1);
    end
endmodule
